mbox_req_seq: RTL
=================

MBOX_REQ_SEQ -- requirements
Module: mbox_req_seq

Interface
REQ-001 SHALL clock/reset: clk  in  1  EBOX clock (CLK.MCL domain); RESET  in  1  reset is synchronous and active-high (CLK.MR_RESET).
REQ-002 SHALL MBOX_CYC_REQ  in  1  MCL requests a memory cycle this clock.
REQ-003 SHALL LOAD_AR, LOAD_ARX, VMA_PAUSE, VMA_WRITE, VMA_FETCH  in  1 each  MCL cycle-type qualifiers, valid with MBOX_CYC_REQ.
REQ-004 SHALL VMA  in  23  address bits 13:35, valid with MBOX_CYC_REQ.
REQ-005 SHALL MB_WAIT  in  1  microcode requests stall until the outstanding cycle completes.
REQ-006 SHALL MBOX_ACK, MBOX_RD_DONE, MBOX_WR_DONE, PAGE_FAIL  in  1 each  MBOX accept, read data valid, write complete, page-fail abort.
REQ-007 SHALL PF_CLR  in  1  microcode clears latched page fail/NXM.
REQ-008 SHALL EBOX_REQ, EBOX_RD, EBOX_WR  out  1 each  request to MBOX and its direction.
REQ-009 SHALL EBOX_ADDR  out  23  latched request address.
REQ-010 SHALL RPW_LOCK  out  1  read-pause-write interlock held to MBOX.
REQ-011 SHALL AR_LOAD_EN, ARX_LOAD_EN  out  1 each  one-cycle data-load strobes.
REQ-012 SHALL STALL  out  1  EBOX clock-hold request; PF_HOLD, NXM  out  1 each  sticky error flags; BUSY  out  1  state != IDLE.

Function
REQ-013 SHALL implement states IDLE, REQ, RDWAIT, WRWAIT, PAUSE, FAIL.
REQ-014 SHALL in IDLE on MBOX_CYC_REQ latch VMA and qualifiers, enter REQ next cycle; EBOX_REQ=1 exactly while in REQ.
REQ-015 SHALL classify cycle as read if LOAD_AR|LOAD_ARX|VMA_FETCH, else write if VMA_WRITE; neither set = no cycle, stay IDLE.
REQ-016 SHALL drive EBOX_RD/EBOX_WR from latched class, stable for whole REQ state.
REQ-017 SHALL in REQ on MBOX_ACK go RDWAIT (read) or WRWAIT (write).
REQ-018 SHALL in RDWAIT on MBOX_RD_DONE pulse AR_LOAD_EN (latched LOAD_AR or VMA_FETCH) and/or ARX_LOAD_EN (latched LOAD_ARX) for one cycle; go PAUSE if latched VMA_PAUSE, else IDLE.
REQ-019 SHALL in WRWAIT on MBOX_WR_DONE go IDLE.
REQ-020 SHALL assert RPW_LOCK from REQ of a pause read through completion of the following write; in PAUSE, MBOX_CYC_REQ with VMA_WRITE goes REQ as write reusing latched EBOX_ADDR.
REQ-021 SHALL in PAUSE treat MBOX_CYC_REQ without VMA_WRITE as a new cycle (RPW_LOCK dropped, new address latched).
REQ-022 SHALL STALL = MB_WAIT & state in {REQ,RDWAIT,WRWAIT} | MBOX_CYC_REQ & state in {REQ,RDWAIT,WRWAIT,FAIL}; a stalled request is not accepted, MCL holds it.
REQ-023 SHALL on RD_DONE/WR_DONE coincident with MBOX_CYC_REQ finish the current cycle; new request accepted the following cycle (STALL asserted that cycle).
REQ-024 SHALL on PAGE_FAIL in any non-IDLE state go FAIL, drop EBOX_REQ and RPW_LOCK, suppress load strobes, set PF_HOLD; PAGE_FAIL in IDLE ignored.
REQ-025 SHALL keep an 8-bit watchdog counting cycles in REQ/RDWAIT/WRWAIT, cleared on every state change; at 255 set NXM, go FAIL.
REQ-026 SHALL leave FAIL to IDLE only on PF_CLR, which also clears PF_HOLD and NXM; PAGE_FAIL and ACK in same cycle: PAGE_FAIL wins.

Reset
REQ-027 SHALL on RESET (any state, mid-cycle included) go IDLE next edge; all outputs 0, EBOX_ADDR 0, watchdog 0, PF_HOLD/NXM cleared; RESET overrides all inputs.

Verification
REQ-028 SHALL read: CYC_REQ, LOAD_AR, VMA=0o1234 -> EBOX_REQ/RD 1 cycle later, ACK, RD_DONE after 3 cycles -> AR_LOAD_EN one cycle, IDLE.
REQ-029 SHALL RPW: LOAD_AR+PAUSE at 0o500, complete read, then CYC_REQ+WRITE -> EBOX_WR at 0o500, RPW_LOCK high throughout until WR_DONE.
REQ-030 SHALL MB_WAIT during RDWAIT -> STALL high until RD_DONE cycle, low next cycle; second CYC_REQ while busy -> STALL, accepted after completion.
REQ-031 SHALL PAGE_FAIL in RDWAIT coincident with RD_DONE -> no load strobe, PF_HOLD=1, FAIL until PF_CLR.
REQ-032 SHALL no ACK for 255 cycles -> NXM=1, FAIL; RESET asserted in WRWAIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mbox_req_seq.sv
// EBOX-side memory request sequencer: turns MCL cycle requests into MBOX
// requests, tracks read-pause-write interlocks, page fails and NXM timeouts.
module mbox_req_seq (
  input  logic        clk,
  input  logic        RESET,
  input  logic        MBOX_CYC_REQ,
  input  logic        LOAD_AR,
  input  logic        LOAD_ARX,
  input  logic        VMA_PAUSE,
  input  logic        VMA_WRITE,
  input  logic        VMA_FETCH,
  input  logic [22:0] VMA,
  input  logic        MB_WAIT,
  input  logic        MBOX_ACK,
  input  logic        MBOX_RD_DONE,
  input  logic        MBOX_WR_DONE,
  input  logic        PAGE_FAIL,
  input  logic        PF_CLR,
  output logic        EBOX_REQ,
  output logic        EBOX_RD,
  output logic        EBOX_WR,
  output logic [22:0] EBOX_ADDR,
  output logic        RPW_LOCK,
  output logic        AR_LOAD_EN,
  output logic        ARX_LOAD_EN,
  output logic        STALL,
  output logic        PF_HOLD,
  output logic        NXM,
  output logic        BUSY
);

  localparam int unsigned WD_W   = 8;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(255);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_RDWAIT, S_WRWAIT, S_PAUSE, S_FAIL
  } state_t;

  state_t          state;
  logic            rd_q;
  logic            ld_ar_q;
  logic            ld_arx_q;
  logic            pause_q;
  logic [WD_W-1:0] wd;

  logic new_rd;
  logic new_wr;
  logic wait_st;

  assign new_rd  = LOAD_AR | LOAD_ARX | VMA_FETCH;
  assign new_wr  = ~new_rd & VMA_WRITE;
  assign wait_st = (state == S_REQ) || (state == S_RDWAIT) || (state == S_WRWAIT);

  // State decodes; MBOX sees direction only while the request is up.
  assign EBOX_REQ = (state == S_REQ);
  assign EBOX_RD  = EBOX_REQ & rd_q;
  assign EBOX_WR  = EBOX_REQ & ~rd_q;
  assign BUSY     = (state != S_IDLE);
  assign STALL    = (MB_WAIT & wait_st) | (MBOX_CYC_REQ & (wait_st | (state == S_FAIL)));

  always_ff @(posedge clk) begin
    if (RESET) begin
      state       <= S_IDLE;
      rd_q        <= 1'b0;
      ld_ar_q     <= 1'b0;
      ld_arx_q    <= 1'b0;
      pause_q     <= 1'b0;
      wd          <= '0;
      EBOX_ADDR   <= '0;
      RPW_LOCK    <= 1'b0;
      AR_LOAD_EN  <= 1'b0;
      ARX_LOAD_EN <= 1'b0;
      PF_HOLD     <= 1'b0;
      NXM         <= 1'b0;
    end else begin
      AR_LOAD_EN  <= 1'b0;
      ARX_LOAD_EN <= 1'b0;
      wd          <= '0;
      if (PF_CLR) begin
        PF_HOLD <= 1'b0;
        NXM     <= 1'b0;
      end
      if (PAGE_FAIL && (state != S_IDLE)) begin
        state    <= S_FAIL;
        PF_HOLD  <= 1'b1;
        RPW_LOCK <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (MBOX_CYC_REQ && (new_rd || new_wr)) begin
              state     <= S_REQ;
              EBOX_ADDR <= VMA;
              rd_q      <= new_rd;
              ld_ar_q   <= LOAD_AR | VMA_FETCH;
              ld_arx_q  <= LOAD_ARX;
              pause_q   <= VMA_PAUSE;
              RPW_LOCK  <= new_rd & VMA_PAUSE;
            end
          end
          S_REQ: begin
            if (MBOX_ACK) begin
              state <= rd_q ? S_RDWAIT : S_WRWAIT;
            end else if (wd == WD_MAX) begin
              state    <= S_FAIL;
              NXM      <= 1'b1;
              RPW_LOCK <= 1'b0;
            end else begin
              wd <= wd + WD_W'(1);
            end
          end
          S_RDWAIT: begin
            if (MBOX_RD_DONE) begin
              AR_LOAD_EN  <= ld_ar_q;
              ARX_LOAD_EN <= ld_arx_q;
              state       <= pause_q ? S_PAUSE : S_IDLE;
              if (!pause_q) RPW_LOCK <= 1'b0;
            end else if (wd == WD_MAX) begin
              state    <= S_FAIL;
              NXM      <= 1'b1;
              RPW_LOCK <= 1'b0;
            end else begin
              wd <= wd + WD_W'(1);
            end
          end
          S_WRWAIT: begin
            if (MBOX_WR_DONE) begin
              state    <= S_IDLE;
              RPW_LOCK <= 1'b0;
            end else if (wd == WD_MAX) begin
              state    <= S_FAIL;
              NXM      <= 1'b1;
              RPW_LOCK <= 1'b0;
            end else begin
              wd <= wd + WD_W'(1);
            end
          end
          S_PAUSE: begin
            // A write completes the interlocked pair; anything else starts afresh.
            if (MBOX_CYC_REQ) begin
              if (VMA_WRITE) begin
                state    <= S_REQ;
                rd_q     <= 1'b0;
                ld_ar_q  <= 1'b0;
                ld_arx_q <= 1'b0;
                pause_q  <= 1'b0;
              end else if (new_rd) begin
                state     <= S_REQ;
                EBOX_ADDR <= VMA;
                rd_q      <= 1'b1;
                ld_ar_q   <= LOAD_AR | VMA_FETCH;
                ld_arx_q  <= LOAD_ARX;
                pause_q   <= VMA_PAUSE;
                RPW_LOCK  <= VMA_PAUSE;
              end else begin
                state    <= S_IDLE;
                RPW_LOCK <= 1'b0;
              end
            end
          end
          S_FAIL: begin
            if (PF_CLR) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
